// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle for unified_mem_arbiter: the core's fetch and data ports on
// one side and the shared single-ported memory on the other. The arbiter
// takes the slave view; the core/memory side takes the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Instruction-fetch port
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  read_instr_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  instr_ready_o;

  // Data-memory port
  logic [ADDR_WIDTH-1:0] dmem_addr_i;
  logic [DATA_WIDTH-1:0] dmem_wdata_i;
  logic                  dmem_write_i;
  logic [STRB_WIDTH-1:0] dmem_wstrb_i;
  logic                  dmem_read_i;
  logic [DATA_WIDTH-1:0] dmem_rdata_o;
  logic                  dmem_ready_o;

  // Shared memory port
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ready_i;

  // Sticky protocol-error flag
  logic                  proto_err_o;

  modport slave (
    input  pc_i, read_instr_i,
    input  dmem_addr_i, dmem_wdata_i, dmem_write_i, dmem_wstrb_i, dmem_read_i,
    input  mem_rdata_i, mem_ready_i,
    output instr_o, instr_ready_o,
    output dmem_rdata_o, dmem_ready_o,
    output mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_read_o, mem_write_o,
    output proto_err_o
  );

  modport master (
    output pc_i, read_instr_i,
    output dmem_addr_i, dmem_wdata_i, dmem_write_i, dmem_wstrb_i, dmem_read_i,
    output mem_rdata_i, mem_ready_i,
    input  instr_o, instr_ready_o,
    input  dmem_rdata_o, dmem_ready_o,
    input  mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_read_o, mem_write_o,
    input  proto_err_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the core's instruction-fetch port
// and its data port. Single-cycle request pulses are latched into one pending
// slot per port; one memory transaction runs at a time, data accesses win
// over fetches, and completion is reported with a one-cycle ready pulse that
// is combinational from the memory's own ready.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D
  } state_t;

  state_t                r_state;

  // Instruction pending slot
  logic                  r_iPend;
  logic [ADDR_WIDTH-1:0] r_iAddr;

  // Data pending slot
  logic                  r_dPend;
  logic                  r_dIsRead;
  logic [ADDR_WIDTH-1:0] r_dAddr;
  logic [DATA_WIDTH-1:0] r_dWdata;
  logic [STRB_WIDTH-1:0] r_dWstrb;

  logic                  r_protoErr;

  logic                  w_iDone;
  logic                  w_dDone;
  logic                  w_iFree;
  logic                  w_dFree;
  logic                  w_dReq;
  logic                  w_iAccept;
  logic                  w_dAccept;
  logic                  w_protoViol;

  // A slot completing this cycle counts as free, so a core that reacts to the
  // ready pulse with an immediate new request is not flagged.
  always_comb begin
    w_iDone     = (r_state == ST_BUSY_I) && bus.mem_ready_i;
    w_dDone     = (r_state == ST_BUSY_D) && bus.mem_ready_i;
    w_iFree     = !r_iPend || w_iDone;
    w_dFree     = !r_dPend || w_dDone;
    w_dReq      = bus.dmem_read_i || bus.dmem_write_i;
    w_iAccept   = bus.read_instr_i && w_iFree;
    w_dAccept   = w_dReq && w_dFree;
    w_protoViol = (bus.read_instr_i && !w_iFree) ||
                  (w_dReq && !w_dFree) ||
                  (bus.dmem_read_i && bus.dmem_write_i);
  end

  // Transaction sequencer: Idle looks at both latched and just-arriving
  // requests so a fresh pulse reaches the memory on the very next cycle;
  // every completion returns through Idle, giving one gap cycle between
  // back-to-back transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_dPend || w_dAccept) begin
            r_state <= ST_BUSY_D;
          end else if (r_iPend || w_iAccept) begin
            r_state <= ST_BUSY_I;
          end
        end
        ST_BUSY_I: begin
          if (bus.mem_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY_D: begin
          if (bus.mem_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Instruction slot: capture a fetch pulse when free, release on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iPend <= 1'b0;
      r_iAddr <= '0;
    end else if (w_iAccept) begin
      r_iPend <= 1'b1;
      r_iAddr <= bus.pc_i;
    end else if (w_iDone) begin
      r_iPend <= 1'b0;
    end
  end

  // Data slot: capture a load/store pulse when free (load wins if both are
  // raised), release on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dPend   <= 1'b0;
      r_dIsRead <= 1'b0;
      r_dAddr   <= '0;
      r_dWdata  <= '0;
      r_dWstrb  <= '0;
    end else if (w_dAccept) begin
      r_dPend   <= 1'b1;
      r_dIsRead <= bus.dmem_read_i;
      r_dAddr   <= bus.dmem_addr_i;
      r_dWdata  <= bus.dmem_wdata_i;
      r_dWstrb  <= bus.dmem_wstrb_i;
    end else if (w_dDone) begin
      r_dPend   <= 1'b0;
    end
  end

  // Protocol-error flag latches on any rejected or contradictory request and
  // only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_protoErr <= 1'b0;
    end else if (w_protoViol) begin
      r_protoErr <= 1'b1;
    end
  end

  // Memory command is driven from the latched slot for the whole Busy state;
  // ready and read data pass straight through in the completion cycle.
  always_comb begin
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;
    bus.mem_wstrb_o   = '0;
    bus.mem_read_o    = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.instr_o       = '0;
    bus.instr_ready_o = 1'b0;
    bus.dmem_rdata_o  = '0;
    bus.dmem_ready_o  = 1'b0;
    case (r_state)
      ST_BUSY_I: begin
        bus.mem_addr_o    = r_iAddr;
        bus.mem_read_o    = 1'b1;
        bus.instr_ready_o = bus.mem_ready_i;
        if (bus.mem_ready_i) begin
          bus.instr_o = bus.mem_rdata_i;
        end
      end
      ST_BUSY_D: begin
        bus.mem_addr_o   = r_dAddr;
        bus.mem_read_o   = r_dIsRead;
        bus.mem_write_o  = !r_dIsRead;
        if (!r_dIsRead) begin
          bus.mem_wdata_o = r_dWdata;
          bus.mem_wstrb_o = r_dWstrb;
        end
        bus.dmem_ready_o = bus.mem_ready_i;
        if (bus.mem_ready_i && r_dIsRead) begin
          bus.dmem_rdata_o = bus.mem_rdata_i;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.proto_err_o = r_protoErr;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter. A timestamp-based model keeps
// the outstanding request per port and the cycle from which the memory is
// free again, and predicts every output every cycle. Directed sequences cover
// the headline scenarios; randomized traffic follows.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NONE  = 0;
  localparam int SRV_I = 1;
  localparam int SRV_D = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  // Reference model state
  bit          iOut, dOut, dIsRead, protoExp;
  logic [31:0] iAddr, dAddr, dWdata;
  logic [3:0]  dWstrb;
  int          iReqCyc, dReqCyc;
  int          cur, nextFree, waitLeft, waitCfg;
  bit          memReadyNow;
  logic [31:0] rdataNow;
  logic [31:0] memArr [256];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               tag, cycle, observed, expected);
    end
  endtask

  task automatic clearModel();
    cur      = NONE;
    iOut     = 1'b0;
    dOut     = 1'b0;
    protoExp = 1'b0;
    nextFree = cycle;
  endtask

  // Decide which request the memory is serving this cycle and drive the
  // memory's response (ready after a chosen number of wait cycles).
  task automatic modelPre();
    if (cur == NONE && cycle >= nextFree) begin
      if (dOut && dReqCyc < cycle) cur = SRV_D;
      else if (iOut && iReqCyc < cycle) cur = SRV_I;
      if (cur != NONE) waitLeft = (waitCfg < 0) ? int'($urandom_range(3, 0)) : waitCfg;
    end
    if (cur != NONE) begin
      memReadyNow = (waitLeft == 0);
      if (!memReadyNow) waitLeft--;
    end else begin
      memReadyNow = (waitCfg == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    end
    if (cur == SRV_I) rdataNow = memArr[iAddr[9:2]];
    else if (cur == SRV_D && dIsRead) rdataNow = memArr[dAddr[9:2]];
    else rdataNow = $urandom;
    bus.mem_ready_i = memReadyNow;
    bus.mem_rdata_i = rdataNow;
  endtask

  // Drive this cycle's core requests, check every output, then advance the
  // model across the coming clock edge.
  task automatic applyStimulus(input bit iReq, input logic [31:0] pc,
                               input bit dRd, input bit dWr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    bit          expWr, expRd, doneI, doneD;
    logic [31:0] expAddr;
    bus.read_instr_i = iReq;
    bus.pc_i         = pc;
    bus.dmem_read_i  = dRd;
    bus.dmem_write_i = dWr;
    bus.dmem_addr_i  = addr;
    bus.dmem_wdata_i = wdata;
    bus.dmem_wstrb_i = wstrb;
    #1;
    doneI   = (cur == SRV_I) && memReadyNow;
    doneD   = (cur == SRV_D) && memReadyNow;
    expRd   = (cur == SRV_I) || (cur == SRV_D && dIsRead);
    expWr   = (cur == SRV_D) && !dIsRead;
    expAddr = (cur == SRV_I) ? iAddr : (cur == SRV_D) ? dAddr : 32'h0;
    checkOutput("memRead",  bus.mem_read_o,  expRd);
    checkOutput("memWrite", bus.mem_write_o, expWr);
    checkOutput("memAddr",  bus.mem_addr_o,  expAddr);
    if (expWr) begin
      checkOutput("memWdata", bus.mem_wdata_o, dWdata);
      checkOutput("memWstrb", bus.mem_wstrb_o, dWstrb);
    end else if (cur == NONE) begin
      checkOutput("idleWdata", {bus.mem_wdata_o, 28'h0, bus.mem_wstrb_o}, 64'h0);
    end
    checkOutput("instrReady", bus.instr_ready_o, doneI);
    checkOutput("instr", bus.instr_o, doneI ? rdataNow : 32'h0);
    checkOutput("dmemReady", bus.dmem_ready_o, doneD);
    if (!(doneD && !dIsRead))
      checkOutput("dmemRdata", bus.dmem_rdata_o, (doneD && dIsRead) ? rdataNow : 32'h0);
    checkOutput("protoErr", bus.proto_err_o, protoExp);

    if (doneI) iOut = 1'b0;
    if (doneD) begin
      if (!dIsRead)
        for (int b = 0; b < 4; b++)
          if (dWstrb[b]) memArr[dAddr[9:2]][8*b +: 8] = dWdata[8*b +: 8];
      dOut = 1'b0;
    end
    if (doneI || doneD) begin
      cur      = NONE;
      nextFree = cycle + 2;
    end
    if (iReq) begin
      if (iOut) protoExp = 1'b1;
      else begin
        iOut = 1'b1; iAddr = pc; iReqCyc = cycle;
      end
    end
    if (dRd || dWr) begin
      if (dRd && dWr) protoExp = 1'b1;
      if (dOut) protoExp = 1'b1;
      else begin
        dOut = 1'b1; dIsRead = dRd; dAddr = addr; dWdata = wdata;
        dWstrb = wstrb; dReqCyc = cycle;
      end
    end
    cycle++;
  endtask

  task automatic stepReq(input bit iReq, input logic [31:0] pc, input bit dRd,
                         input bit dWr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    @(negedge clk);
    modelPre();
    applyStimulus(iReq, pc, dRd, dWr, addr, wdata, wstrb);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) stepReq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic waitIdle();
    int budget = 60;
    while ((iOut || dOut || cur != NONE) && budget > 0) begin
      idleCycles(1);
      budget--;
    end
    checkOutput("drainTimeout", budget == 0, 1'b0);
    idleCycles(1);
  endtask

  task automatic clearInputs();
    bus.read_instr_i = 1'b0; bus.pc_i = '0;
    bus.dmem_read_i = 1'b0; bus.dmem_write_i = 1'b0;
    bus.dmem_addr_i = '0; bus.dmem_wdata_i = '0; bus.dmem_wstrb_i = '0;
    bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Cmd"}, {bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o}, 64'h0);
    checkOutput({tag, "Wr"}, {bus.mem_wdata_o, 28'h0, bus.mem_wstrb_o}, 64'h0);
    checkOutput({tag, "Rdy"}, {bus.instr_ready_o, bus.dmem_ready_o, bus.proto_err_o}, 64'h0);
    checkOutput({tag, "Data"}, {bus.instr_o, bus.dmem_rdata_o}, 64'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic resetDut();
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("rstMid");
    clearInputs();
    clearModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomTraffic(input int n);
    bit          iFree, dFree, doI, doD, isWr;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      modelPre();
      iFree = !iOut || (cur == SRV_I && memReadyNow);
      dFree = !dOut || (cur == SRV_D && memReadyNow);
      doI   = iFree && ($urandom_range(3, 0) == 0);
      doD   = dFree && ($urandom_range(3, 0) == 0);
      isWr  = 1'($urandom_range(1, 0));
      a     = $urandom & 32'h0000_3FFC;
      applyStimulus(doI, $urandom & 32'h0000_0FFC, doD && !isWr, doD && isWr,
                    a, $urandom, 4'($urandom_range(15, 0)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 256; k++) memArr[k] = $urandom;
    memArr[8'h40] = 32'h0050_0093;
    waitCfg = -1;
    rst_n   = 1'b0;
    clearInputs();
    clearModel();
    repeat (3) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch with two wait cycles: command for three cycles.
    waitCfg = 2;
    stepReq(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitIdle();

    // Fetch and load in the same cycle: load served first.
    waitCfg = 1;
    stepReq(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    waitIdle();

    // Store arriving while a fetch is in service, then read it back.
    waitCfg = 3;
    stepReq(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stepReq(1'b0, 32'h0, 1'b0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hF);
    waitIdle();
    waitCfg = 0;
    stepReq(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0);
    waitIdle();

    // Zero-wait back-to-back fetches, each new pulse on the completion cycle.
    stepReq(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stepReq(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idleCycles(1);
    stepReq(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitIdle();

    // Second fetch pulse while the first is pending: ignored, error sticks.
    waitCfg = 4;
    stepReq(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stepReq(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitIdle();
    idleCycles(3);

    // Load and store raised together: load wins.
    waitCfg = 1;
    stepReq(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h1234_5678, 4'hF);
    waitIdle();

    // Reset while a store is in service: no ready for it afterwards.
    waitCfg = 6;
    stepReq(1'b0, 32'h0, 1'b0, 1'b1, 32'h2008, 32'hCAFE_F00D, 4'h3);
    idleCycles(2);
    resetDut();
    waitCfg = -1;
    idleCycles(6);

    // Randomized traffic with random and then zero wait states.
    randomTraffic(1500);
    waitIdle();
    waitCfg = 0;
    randomTraffic(500);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
